eq_filter_bank: RTL and testbench

Parametrised, time-multiplexed FIR filter bank for the audio equaliser. One shared multiply-accumulate engine computes NUM_BANDS programmable TAPS-tap FIR bands per input sample. It replaces the fixed eight-instance filter wrapper. It adds per-band enable and gain, runtime coefficient loading, a valid/ready sample handshake and a saturated mixed output. It sits between the sample source and the equaliser output stage.

---
 rtl/eq_pkg.sv | 43 ++++
 rtl/eq_coef_mem.sv | 37 +++
 rtl/eq_filter_bank.sv | 154 +++++++++++++++
 tb/tb_eq_filter_bank.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared types and width/saturation helpers for the equaliser filter bank.
package eq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_STORE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Working width of the saturation helper; wide enough for any sane mix accumulator.
  localparam int unsigned SAT_W = 128;

  // Per-band accumulator width: full product plus tap growth.
  function automatic int unsigned acc_w(input int unsigned data_w,
                                        input int unsigned coef_w,
                                        input int unsigned taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Mix accumulator width: band result times gain, band growth and the gain sign bit.
  function automatic int unsigned mix_w(input int unsigned acc_width,
                                        input int unsigned gain_w,
                                        input int unsigned num_bands);
    return acc_width + gain_w + $clog2(num_bands) + 1;
  endfunction

  // Arithmetic right shift, then clamp to the signed range of out_w bits.
  function automatic logic signed [SAT_W-1:0] sat_shift(input logic signed [SAT_W-1:0] val,
                                                        input int unsigned sh,
                                                        input int unsigned out_w);
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    shifted = val >>> sh;
    hi      = (SAT_W'(1) << (out_w - 1)) - SAT_W'(1);
    lo      = ~hi;
    if (shifted > hi) return hi;
    if (shifted < lo) return lo;
    return shifted;
  endfunction

endpackage

// File: rtl/eq_coef_mem.sv
// Coefficient store: NUM_BANDS x TAPS registers, synchronous write, combinational read.
module eq_coef_mem #(
  parameter  int unsigned NUM_BANDS = 8,
  parameter  int unsigned TAPS      = 16,
  parameter  int unsigned COEF_W    = 16,
  localparam int unsigned BAND_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1,
  localparam int unsigned TAP_W     = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [BAND_W-1:0]        wband,
  input  logic [TAP_W-1:0]         widx,
  input  logic signed [COEF_W-1:0] wdata,
  input  logic [BAND_W-1:0]        rband,
  input  logic [TAP_W-1:0]         ridx,
  output logic signed [COEF_W-1:0] rdata_c
);

  logic signed [COEF_W-1:0] mem [NUM_BANDS][TAPS];

  // Register array: cleared on reset, one coefficient written per strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < int'(NUM_BANDS); b++) begin
        for (int t = 0; t < int'(TAPS); t++) begin
          mem[b][t] <= '0;
        end
      end
    end else if (we) begin
      mem[wband][widx] <= wdata;
    end
  end

  assign rdata_c = mem[rband][ridx];

endmodule

// File: rtl/eq_filter_bank.sv
// Time-multiplexed FIR filter bank: one MAC engine serves all bands, then a saturated gain mix.
module eq_filter_bank
  import eq_pkg::*;
#(
  parameter  int unsigned NUM_BANDS = 8,
  parameter  int unsigned TAPS      = 16,
  parameter  int unsigned DATA_W    = 16,
  parameter  int unsigned COEF_W    = 16,
  parameter  int unsigned GAIN_W    = 8,
  parameter  int unsigned GAIN_FRAC = 6,
  localparam int unsigned ACC_W     = acc_w(DATA_W, COEF_W, TAPS),
  localparam int unsigned BAND_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1,
  localparam int unsigned TAP_W     = $clog2(TAPS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DATA_W-1:0]    x_in,
  input  logic                        x_valid,
  output logic                        x_ready,
  input  logic [NUM_BANDS-1:0]        ena,
  input  logic [NUM_BANDS*GAIN_W-1:0] gain,
  input  logic                        coef_we,
  input  logic [BAND_W-1:0]           coef_band,
  input  logic [TAP_W-1:0]            coef_idx,
  input  logic signed [COEF_W-1:0]    coef_data,
  output logic                        coef_err,
  output logic [NUM_BANDS*ACC_W-1:0]  y_band,
  output logic signed [ACC_W-1:0]     y_mix,
  output logic                        y_valid
);

  localparam int unsigned MIX_W  = mix_w(ACC_W, GAIN_W, NUM_BANDS);
  localparam int unsigned PROD_W = DATA_W + COEF_W;

  state_t                   state_q, state_nxt;
  logic signed [DATA_W-1:0] x_dl [TAPS];
  logic [NUM_BANDS-1:0]     ena_q;
  logic [GAIN_W-1:0]        gain_q [NUM_BANDS];
  logic [BAND_W-1:0]        band_q;
  logic [TAP_W-1:0]         tap_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [MIX_W-1:0]  mix_q;
  logic signed [ACC_W-1:0]  shadow_q [NUM_BANDS];

  logic                     accept_c;
  logic                     last_tap_c;
  logic                     last_band_c;
  logic signed [COEF_W-1:0] coef_rd_c;
  logic signed [PROD_W-1:0] mac_prod_c;
  logic signed [ACC_W-1:0]  band_res_c;
  logic signed [MIX_W-1:0]  mix_add_c;

  // Coefficients are only writable while idle so a sample never sees a half-updated band.
  eq_coef_mem #(
    .NUM_BANDS (NUM_BANDS),
    .TAPS      (TAPS),
    .COEF_W    (COEF_W)
  ) u_coef_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (coef_we && (state_q == ST_IDLE)),
    .wband   (coef_band),
    .widx    (coef_idx),
    .wdata   (coef_data),
    .rband   (band_q),
    .ridx    (tap_q),
    .rdata_c (coef_rd_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic: every band runs all taps plus a store cycle, enabled or not.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (x_valid) state_nxt = ST_MAC;
      ST_MAC:   if (last_tap_c) state_nxt = ST_STORE;
      ST_STORE: state_nxt = last_band_c ? ST_DONE : ST_MAC;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath terms: tap product, gated band result and its gain-weighted contribution.
  always_comb begin
    accept_c    = x_valid && (state_q == ST_IDLE);
    last_tap_c  = (tap_q == TAP_W'(TAPS - 1));
    last_band_c = (band_q == BAND_W'(NUM_BANDS - 1));
    mac_prod_c  = PROD_W'(x_dl[tap_q]) * PROD_W'(coef_rd_c);
    band_res_c  = ena_q[band_q] ? acc_q : '0;
    mix_add_c   = MIX_W'(band_res_c) * MIX_W'($signed({1'b0, gain_q[band_q]}));
  end

  // Delay line, MAC, shadow results, mixer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < int'(TAPS); t++) x_dl[t] <= '0;
      for (int b = 0; b < int'(NUM_BANDS); b++) begin
        gain_q[b]   <= '0;
        shadow_q[b] <= '0;
      end
      ena_q    <= '0;
      band_q   <= '0;
      tap_q    <= '0;
      acc_q    <= '0;
      mix_q    <= '0;
      y_band   <= '0;
      y_mix    <= '0;
      y_valid  <= 1'b0;
      coef_err <= 1'b0;
      x_ready  <= 1'b1;
    end else begin
      x_ready  <= (state_nxt == ST_IDLE);
      coef_err <= coef_we && (state_q != ST_IDLE);
      y_valid  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            x_dl[0] <= x_in;
            for (int t = 1; t < int'(TAPS); t++) x_dl[t] <= x_dl[t-1];
            for (int b = 0; b < int'(NUM_BANDS); b++) gain_q[b] <= gain[b*GAIN_W +: GAIN_W];
            ena_q  <= ena;
            band_q <= '0;
            tap_q  <= '0;
            acc_q  <= '0;
            mix_q  <= '0;
          end
        end
        ST_MAC: begin
          acc_q <= acc_q + ACC_W'(mac_prod_c);
          tap_q <= tap_q + TAP_W'(1);
        end
        ST_STORE: begin
          shadow_q[band_q] <= band_res_c;
          mix_q            <= mix_q + mix_add_c;
          acc_q            <= '0;
          tap_q            <= '0;
          if (!last_band_c) band_q <= band_q + BAND_W'(1);
        end
        ST_DONE: begin
          for (int b = 0; b < int'(NUM_BANDS); b++) y_band[b*ACC_W +: ACC_W] <= shadow_q[b];
          y_mix   <= ACC_W'(sat_shift(SAT_W'(mix_q), GAIN_FRAC, ACC_W));
          y_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_filter_bank.sv
// Directed self-checking bench for eq_filter_bank at default parameters.
module tb_eq_filter_bank;

  localparam int NB    = 8;
  localparam int ACC_W = 36;
  localparam int LAT   = 137;
  localparam int NV    = 23;

  logic                    clk;
  logic                    rst;
  logic signed [15:0]      x_in;
  logic                    x_valid;
  logic                    x_ready;
  logic [NB-1:0]           ena;
  logic [NB*8-1:0]         gain;
  logic                    coef_we;
  logic [2:0]              coef_band;
  logic [3:0]              coef_idx;
  logic signed [15:0]      coef_data;
  logic                    coef_err;
  logic [NB*ACC_W-1:0]     y_band;
  logic signed [ACC_W-1:0] y_mix;
  logic                    y_valid;

  int checks;
  int failures;

  typedef struct {
    logic signed [15:0] x;
    logic [7:0]         ena;
    logic [7:0]         g;
    longint             on;
    longint             mix;
    bit                 reprog;
  } vec_t;

  vec_t vecs [NV];

  eq_filter_bank dut (
    .clk       (clk),
    .rst       (rst),
    .x_in      (x_in),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .ena       (ena),
    .gain      (gain),
    .coef_we   (coef_we),
    .coef_band (coef_band),
    .coef_idx  (coef_idx),
    .coef_data (coef_data),
    .coef_err  (coef_err),
    .y_band    (y_band),
    .y_mix     (y_mix),
    .y_valid   (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint get_band(input int b);
    logic signed [ACC_W-1:0] t;
    t = y_band[b*ACC_W +: ACC_W];
    return longint'(t);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wcoef(input int b, input int k, input int d);
    coef_we   = 1'b1;
    coef_band = 3'(b);
    coef_idx  = 4'(k);
    coef_data = 16'(d);
    step();
    coef_we   = 1'b0;
  endtask

  // Present one sample and let it be taken; ena/gain are scrubbed afterwards to prove they were latched.
  task automatic accept(input logic signed [15:0] xv, input logic [7:0] e, input logic [7:0] g);
    int n;
    n = 0;
    while (!x_ready && n < 400) begin
      step();
      n++;
    end
    chk("ready_before_accept", longint'(x_ready), 64'sd1);
    x_in    = xv;
    ena     = e;
    gain    = {NB{g}};
    x_valid = 1'b1;
    step();
    x_valid = 1'b0;
    ena     = '0;
    gain    = '0;
  endtask

  // Wait for y_valid, counting edges since the accept; start is the count already elapsed.
  task automatic wait_y(input int start);
    int  n;
    bit  seen;
    n    = start;
    seen = 1'b0;
    while (!seen && n < 300) begin
      step();
      n++;
      if (y_valid) seen = 1'b1;
    end
    chk("latency", longint'(n), longint'(LAT));
    step();
    chk("y_valid_one_cycle", longint'(y_valid), 64'sd0);
  endtask

  task automatic send(input logic signed [15:0] xv, input logic [7:0] e, input logic [7:0] g);
    accept(xv, e, g);
    wait_y(0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int  acc_cnt;
    int  acc_at [3];
    bit  yv_second;
    bit  rb;
    bit  yb;
    int  yv_seen;
    longint exp_b;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    x_in     = '0;
    x_valid  = 1'b0;
    ena      = '0;
    gain     = '0;
    coef_we  = 1'b0;
    coef_band = '0;
    coef_idx = '0;
    coef_data = '0;

    // Impulse through band 0 with coef[k] = k+1, unity gain.
    for (int n = 0; n < 16; n++) begin
      vecs[n].x      = (n == 0) ? 16'sd1 : 16'sd0;
      vecs[n].ena    = 8'h01;
      vecs[n].g      = 8'd64;
      vecs[n].on     = longint'(n + 1);
      vecs[n].mix    = longint'(n + 1);
      vecs[n].reprog = 1'b0;
    end
    // Every band has coef[0]=100 only; exercises enables, gain scaling and arithmetic shift rounding.
    vecs[16] = '{x: 16'sd10,  ena: 8'hAA, g: 8'd128, on: 1000,  mix: 8000,  reprog: 1'b1};
    vecs[17] = '{x: -16'sd7,  ena: 8'h0F, g: 8'd64,  on: -700,  mix: -2800, reprog: 1'b0};
    vecs[18] = '{x: 16'sd5,   ena: 8'hFF, g: 8'd32,  on: 500,   mix: 2000,  reprog: 1'b0};
    vecs[19] = '{x: 16'sd1,   ena: 8'h01, g: 8'd3,   on: 100,   mix: 4,     reprog: 1'b0};
    vecs[20] = '{x: -16'sd1,  ena: 8'h01, g: 8'd3,   on: -100,  mix: -5,    reprog: 1'b0};
    vecs[21] = '{x: 16'sd100, ena: 8'h80, g: 8'd255, on: 10000, mix: 39843, reprog: 1'b0};
    vecs[22] = '{x: 16'sd3,   ena: 8'h00, g: 8'd200, on: 300,   mix: 0,     reprog: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    chk("reset_x_ready", longint'(x_ready), 64'sd1);
    chk("reset_y_valid", longint'(y_valid), 64'sd0);
    chk("reset_coef_err", longint'(coef_err), 64'sd0);
    chk("reset_y_mix", longint'(y_mix), 64'sd0);
    for (int b = 0; b < NB; b++) chk($sformatf("reset_band%0d", b), get_band(b), 64'sd0);

    for (int k = 0; k < 16; k++) wcoef(0, k, k + 1);

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].reprog) begin
        for (int b = 0; b < NB; b++)
          for (int k = 0; k < 16; k++) wcoef(b, k, (k == 0) ? 100 : 0);
      end
      send(vecs[i].x, vecs[i].ena, vecs[i].g);
      for (int b = 0; b < NB; b++) begin
        exp_b = vecs[i].ena[b] ? vecs[i].on : 64'sd0;
        chk($sformatf("v%0d_band%0d", i, b), get_band(b), exp_b);
      end
      chk($sformatf("v%0d_mix", i), longint'(y_mix), vecs[i].mix);
    end

    // Positive and negative saturation with a full history of extreme samples.
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < 16; k++) wcoef(b, k, 32767);
    repeat (16) send(16'sd32767, 8'hFF, 8'd255);
    for (int b = 0; b < NB; b++) chk($sformatf("satpos_band%0d", b), get_band(b), 64'sd17178820624);
    chk("satpos_mix", longint'(y_mix), 64'sd34359738367);
    repeat (16) send(-16'sd32768, 8'hFF, 8'd255);
    for (int b = 0; b < NB; b++) chk($sformatf("satneg_band%0d", b), get_band(b), -64'sd17179344896);
    chk("satneg_mix", longint'(y_mix), -64'sd34359738368);

    // Held x_valid: the IDLE cycle that shows y_valid is also the next accepting cycle,
    // so accepting edges land L+1 edges apart.
    acc_cnt   = 0;
    acc_at    = '{-1, -1, -1};
    yv_second = 1'b0;
    x_in      = 16'sd0;
    ena       = 8'hFF;
    gain      = {NB{8'd64}};
    x_valid   = 1'b1;
    for (int c = 0; c <= 2 * (LAT + 1); c++) begin
      rb = x_ready;
      yb = y_valid;
      step();
      if (rb) begin
        if (acc_cnt < 3) acc_at[acc_cnt] = c;
        if (acc_cnt == 1) yv_second = yb;
        acc_cnt++;
      end
    end
    x_valid = 1'b0;
    chk("hs_accept_count", longint'(acc_cnt), 64'sd3);
    chk("hs_accept0", longint'(acc_at[0]), 64'sd0);
    chk("hs_accept1", longint'(acc_at[1]), longint'(LAT + 1));
    chk("hs_accept2", longint'(acc_at[2]), longint'(2 * (LAT + 1)));
    chk("hs_yvalid_with_accept", longint'(yv_second), 64'sd1);
    wait_y(0);

    // Coefficient write while busy is dropped and flagged.
    pulse_reset();
    wcoef(2, 0, 100);
    accept(16'sd1, 8'hFF, 8'd64);
    repeat (49) step();
    coef_we   = 1'b1;
    coef_band = 3'd2;
    coef_idx  = 4'd3;
    coef_data = 16'sd555;
    chk("busy_coef_err_pre", longint'(coef_err), 64'sd0);
    step();
    coef_we = 1'b0;
    chk("busy_coef_err_pulse", longint'(coef_err), 64'sd1);
    step();
    chk("busy_coef_err_post", longint'(coef_err), 64'sd0);
    wait_y(51);
    chk("busy_band2_first", get_band(2), 64'sd100);
    repeat (3) send(16'sd0, 8'hFF, 8'd64);
    chk("busy_tap3_unchanged", get_band(2), 64'sd0);
    chk("busy_tap3_unchanged_mix", longint'(y_mix), 64'sd0);
    wcoef(2, 3, 555);
    send(16'sd1, 8'hFF, 8'd64);
    chk("idle_write_band2_x1", get_band(2), 64'sd100);
    repeat (3) send(16'sd0, 8'hFF, 8'd64);
    chk("idle_write_tap3", get_band(2), 64'sd555);
    chk("idle_write_tap3_mix", longint'(y_mix), 64'sd555);

    // Reset in the middle of a computation aborts it and clears everything.
    accept(16'sd1, 8'hFF, 8'd64);
    repeat (69) step();
    pulse_reset();
    chk("midrst_x_ready", longint'(x_ready), 64'sd1);
    chk("midrst_y_valid", longint'(y_valid), 64'sd0);
    chk("midrst_y_mix", longint'(y_mix), 64'sd0);
    chk("midrst_band2", get_band(2), 64'sd0);
    chk("midrst_coef_err", longint'(coef_err), 64'sd0);
    yv_seen = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (y_valid) yv_seen++;
    end
    chk("midrst_no_y_valid", longint'(yv_seen), 64'sd0);
    send(16'sd32767, 8'hFF, 8'd64);
    for (int b = 0; b < NB; b++) chk($sformatf("midrst_coef_cleared_band%0d", b), get_band(b), 64'sd0);
    chk("midrst_coef_cleared_mix", longint'(y_mix), 64'sd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
